// File: rtl/frame_color_scan_pkg.sv
// Shared definitions for the frame colour scanner: colour codes, FSM states
// and the RGB444 field positions inside a pixel word.
package frame_color_scan_pkg;

    localparam logic [1:0] COLOR_NONE  = 2'd0;
    localparam logic [1:0] COLOR_RED   = 2'd1;
    localparam logic [1:0] COLOR_GREEN = 2'd2;
    localparam logic [1:0] COLOR_BLUE  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DECIDE,
        ST_DONE
    } state_t;

    // RGB444 layout: {R[11:8], G[7:4], B[3:0]}
    localparam int R_HI = 11;
    localparam int R_LO = 8;
    localparam int G_HI = 7;
    localparam int G_LO = 4;
    localparam int B_HI = 3;
    localparam int B_LO = 0;

endpackage

// File: rtl/frame_pixel_classify.sv
// Combinational RGB444 pixel classifier. A pixel belongs to a colour only when
// that component is the strict maximum and reaches MIN_LVL; any tie for the
// maximum leaves the pixel unclassified.
module frame_pixel_classify
    import frame_color_scan_pkg::*;
#(
    parameter int DW      = 12,
    parameter int MIN_LVL = 4
) (
    input  logic [DW-1:0] pixel,
    output logic [1:0]    pix_class
);

    localparam logic [3:0] LVL = 4'(MIN_LVL);

    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;

    assign r = pixel[R_HI:R_LO];
    assign g = pixel[G_HI:G_LO];
    assign b = pixel[B_HI:B_LO];

    // Strict-maximum test per component.
    always_comb begin
        // NOTE: default assignment first so no path leaves pix_class unassigned (no latch).
        pix_class = COLOR_NONE;
        if (r > g && r > b && r >= LVL) begin
            pix_class = COLOR_RED;
        end else if (g > r && g > b && g >= LVL) begin
            pix_class = COLOR_GREEN;
        end else if (b > r && b > g && b >= LVL) begin
            pix_class = COLOR_BLUE;
        end
    end

endmodule

// File: rtl/frame_color_scan.sv
// Frame-buffer colour scanner: sweeps every pixel address once per request,
// counts red/green/blue pixels and reports the dominant colour of the frame.
module frame_color_scan
    import frame_color_scan_pkg::*;
#(
    parameter int AW        = 15,
    parameter int DW        = 12,
    parameter int IMG_SIZE  = 19200,
    parameter int MIN_LVL   = 4,
    parameter int MIN_COUNT = 100
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic [1:0]    color,
    output logic [AW-1:0] red_cnt,
    output logic [AW-1:0] green_cnt,
    output logic [AW-1:0] blue_cnt
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_SIZE - 1);

    state_t        state;
    logic          rd_valid;
    logic [AW-1:0] r_acc;
    logic [AW-1:0] g_acc;
    logic [AW-1:0] b_acc;
    logic [1:0]    pix_class;
    logic [1:0]    winner;
    logic [AW-1:0] win_cnt;
    logic [1:0]    decided;

    frame_pixel_classify #(
        .DW      (DW),
        .MIN_LVL (MIN_LVL)
    ) u_classify (
        .pixel     (mem_data),
        .pix_class (pix_class)
    );

    // Largest count wins; strict '>' keeps red > green > blue on ties.
    always_comb begin
        winner  = COLOR_RED;
        win_cnt = r_acc;
        if (g_acc > win_cnt) begin
            winner  = COLOR_GREEN;
            win_cnt = g_acc;
        end
        if (b_acc > win_cnt) begin
            winner  = COLOR_BLUE;
            win_cnt = b_acc;
        end
        decided = (32'(win_cnt) < 32'(MIN_COUNT)) ? COLOR_NONE : winner;
    end

    // Scan sequencer with registered handshake, address and result outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            color     <= COLOR_NONE;
            red_cnt   <= '0;
            green_cnt <= '0;
            blue_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_SCAN;
                        busy     <= 1'b1;
                        mem_addr <= '0;
                    end
                end
                ST_SCAN: begin
                    if (mem_addr == LAST_ADDR) begin
                        state <= ST_DRAIN;
                    end else begin
                        mem_addr <= mem_addr + AW'(1);
                    end
                end
                ST_DRAIN: begin
                    state <= ST_DECIDE;
                end
                ST_DECIDE: begin
                    state     <= ST_DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    color     <= decided;
                    red_cnt   <= r_acc;
                    green_cnt <= g_acc;
                    blue_cnt  <= b_acc;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read-data qualifier (one cycle behind SCAN) and per-class pixel counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            r_acc    <= '0;
            g_acc    <= '0;
            b_acc    <= '0;
        end else begin
            rd_valid <= (state == ST_SCAN);
            if (state == ST_IDLE && start) begin
                r_acc <= '0;
                g_acc <= '0;
                b_acc <= '0;
            end else if (rd_valid) begin
                case (pix_class)
                    COLOR_RED:   r_acc <= r_acc + AW'(1);
                    COLOR_GREEN: g_acc <= g_acc + AW'(1);
                    COLOR_BLUE:  b_acc <= b_acc + AW'(1);
                    default:     ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_color_scan.sv
// Scoreboard bench for frame_color_scan: a 4-pixel instance for pattern,
// tie and handshake cases, and a full-size instance for the 160x120 frame.
module tb_frame_color_scan;

    localparam int AW        = 15;
    localparam int S_SIZE    = 4;
    localparam int S_MINCNT  = 1;
    localparam int F_SIZE    = 19200;
    localparam int F_MINCNT  = 100;
    localparam int MIN_LVL   = 4;

    typedef struct {
        int color;
        int r;
        int g;
        int b;
        int start_cyc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // small instance signals
    logic          rst_s = 1'b1, start_s = 1'b0;
    logic          busy_s, done_s;
    logic [AW-1:0] addr_s, rc_s, gc_s, bc_s;
    logic [11:0]   data_s;
    logic [1:0]    color_s;
    logic [11:0]   ram_s [S_SIZE];

    // full instance signals
    logic          rst_f = 1'b1, start_f = 1'b0;
    logic          busy_f, done_f;
    logic [AW-1:0] addr_f, rc_f, gc_f, bc_f;
    logic [11:0]   data_f;
    logic [1:0]    color_f;
    logic [11:0]   ram_f [F_SIZE];

    exp_t q_s[$];
    exp_t q_f[$];
    exp_t e_s;
    exp_t e_f;

    frame_color_scan #(
        .AW(AW), .DW(12), .IMG_SIZE(S_SIZE), .MIN_LVL(MIN_LVL), .MIN_COUNT(S_MINCNT)
    ) dut_s (
        .clk(clk), .rst(rst_s), .start(start_s), .busy(busy_s), .done(done_s),
        .mem_addr(addr_s), .mem_data(data_s), .color(color_s),
        .red_cnt(rc_s), .green_cnt(gc_s), .blue_cnt(bc_s)
    );

    frame_color_scan #(
        .AW(AW), .DW(12), .IMG_SIZE(F_SIZE), .MIN_LVL(MIN_LVL), .MIN_COUNT(F_MINCNT)
    ) dut_f (
        .clk(clk), .rst(rst_f), .start(start_f), .busy(busy_f), .done(done_f),
        .mem_addr(addr_f), .mem_data(data_f), .color(color_f),
        .red_cnt(rc_f), .green_cnt(gc_f), .blue_cnt(bc_f)
    );

    // synchronous-read RAM models
    always @(posedge clk) begin
        data_s <= (int'(addr_s) < S_SIZE) ? ram_s[int'(addr_s)] : 12'h000;
        data_f <= (int'(addr_f) < F_SIZE) ? ram_f[int'(addr_f)] : 12'h000;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference classifier: unique maximum component at or above MIN_LVL.
    function automatic int ref_class(input logic [11:0] px);
        int c[3];
        int mx, n, who;
        c[0] = int'(px[11:8]);
        c[1] = int'(px[7:4]);
        c[2] = int'(px[3:0]);
        mx = c[0];
        foreach (c[i]) if (c[i] > mx) mx = c[i];
        n = 0;
        who = 0;
        foreach (c[i]) if (c[i] == mx) begin n++; who = i; end
        return (n == 1 && mx >= MIN_LVL) ? who + 1 : 0;
    endfunction

    // Reference frame result from a histogram of classes.
    function automatic exp_t ref_frame(input int hist[4], input int min_count);
        exp_t e;
        int best;
        best = 1;
        for (int i = 2; i <= 3; i++) if (hist[i] > hist[best]) best = i;
        e.r = hist[1];
        e.g = hist[2];
        e.b = hist[3];
        e.color = (hist[best] < min_count) ? 0 : best;
        e.start_cyc = 0;
        return e;
    endfunction

    function automatic logic [11:0] rand_px();
        int ch, lvl;
        if ($urandom_range(0, 1) == 0) return 12'($urandom_range(0, 4095));
        ch  = $urandom_range(0, 2);
        lvl = $urandom_range(0, 15);
        return 12'(lvl << (4 * (2 - ch)));
    endfunction

    // Called right after a falling edge; start is high for exactly one cycle.
    task automatic start_small();
        int hist[4];
        exp_t e;
        hist = '{0, 0, 0, 0};
        for (int i = 0; i < S_SIZE; i++) hist[ref_class(ram_s[i])]++;
        e = ref_frame(hist, S_MINCNT);
        e.start_cyc = cyc;
        q_s.push_back(e);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
    endtask

    task automatic start_full();
        int hist[4];
        exp_t e;
        hist = '{0, 0, 0, 0};
        for (int i = 0; i < F_SIZE; i++) hist[ref_class(ram_f[i])]++;
        e = ref_frame(hist, F_MINCNT);
        e.start_cyc = cyc;
        q_f.push_back(e);
        start_f = 1'b1;
        @(negedge clk);
        start_f = 1'b0;
    endtask

    // Returns at the falling edge of the cycle in which done is high.
    task automatic wait_done_s(input string name);
        int n;
        n = 0;
        while (!done_s && n < 40) begin @(negedge clk); n++; end
        if (!done_s) begin
            check({name, "_timeout"}, 0, 1);
            q_s.delete();
        end
    endtask

    task automatic wait_done_f(input string name, input int limit);
        int n;
        n = 0;
        while (!done_f && n < limit) begin @(negedge clk); n++; end
        if (!done_f) begin
            check({name, "_timeout"}, 0, 1);
            q_f.delete();
        end
    endtask

    task automatic load_small(input logic [11:0] a, b, c, d);
        ram_s[0] = a; ram_s[1] = b; ram_s[2] = c; ram_s[3] = d;
    endtask

    // Monitor: compare every done pulse of the small instance with the scoreboard.
    always @(negedge clk) begin
        if (!rst_s && done_s) begin
            if (q_s.size() == 0) begin
                check("s_unexpected_done", 1, 0);
            end else begin
                e_s = q_s.pop_front();
                check("s_color", int'(color_s), e_s.color);
                check("s_red_cnt", int'(rc_s), e_s.r);
                check("s_green_cnt", int'(gc_s), e_s.g);
                check("s_blue_cnt", int'(bc_s), e_s.b);
                check("s_latency", cyc - e_s.start_cyc, S_SIZE + 3);
                check("s_busy_at_done", int'(busy_s), 0);
            end
        end
    end

    // Monitor: same for the full-frame instance.
    always @(negedge clk) begin
        if (!rst_f && done_f) begin
            if (q_f.size() == 0) begin
                check("f_unexpected_done", 1, 0);
            end else begin
                e_f = q_f.pop_front();
                check("f_color", int'(color_f), e_f.color);
                check("f_red_cnt", int'(rc_f), e_f.r);
                check("f_green_cnt", int'(gc_f), e_f.g);
                check("f_blue_cnt", int'(bc_f), e_f.b);
                check("f_latency", cyc - e_f.start_cyc, F_SIZE + 3);
                check("f_busy_at_done", int'(busy_f), 0);
            end
        end
    end

    initial begin
        int errs;
        int n;

        // Reset for two cycles with start held high.
        start_s = 1'b1;
        start_f = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy_s) + int'(busy_f), 0);
        check("rst_done", int'(done_s) + int'(done_f), 0);
        check("rst_addr", int'(addr_s) + int'(addr_f), 0);
        check("rst_color", int'(color_s) + int'(color_f), 0);
        check("rst_counts", int'(rc_s) + int'(gc_s) + int'(bc_s) + int'(rc_f) + int'(gc_f) + int'(bc_f), 0);
        rst_s = 1'b0; rst_f = 1'b0;
        start_s = 1'b0; start_f = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_rst", int'(busy_s) + int'(busy_f), 0);

        // Directed small-frame patterns.
        load_small(12'hF00, 12'hF00, 12'h0F0, 12'h000);
        start_small(); wait_done_s("pat_red");
        @(negedge clk);
        load_small(12'h0F0, 12'h00F, 12'h0F0, 12'h00F);
        start_small(); wait_done_s("pat_tie");
        @(negedge clk);
        load_small(12'h300, 12'h300, 12'h300, 12'h300);
        start_small(); wait_done_s("pat_low");
        @(negedge clk);
        load_small(12'hFF0, 12'h888, 12'h0FF, 12'hF0F);
        start_small(); wait_done_s("pat_ctie");
        @(negedge clk);

        // start during SCAN ignored (latency check in monitor catches a restart).
        load_small(12'h00F, 12'h0F0, 12'h00F, 12'hF00);
        start_small();
        start_s = 1'b1; @(negedge clk); start_s = 1'b0;
        wait_done_s("scan_start");
        // start during DONE ignored.
        start_s = 1'b1; @(negedge clk); start_s = 1'b0;
        repeat (3) @(negedge clk);
        check("done_start_ignored", int'(busy_s), 0);
        repeat (10) @(negedge clk);

        // Back-to-back: new start in the cycle right after DONE.
        load_small(12'h0F0, 12'h0F0, 12'h0F0, 12'h00F);
        start_small(); wait_done_s("b2b_a");
        load_small(12'h00F, 12'h00F, 12'hF00, 12'h000);
        @(negedge clk);
        start_small(); wait_done_s("b2b_b");
        @(negedge clk);

        // Randomized small frames.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < S_SIZE; i++) ram_s[i] = rand_px();
            start_small(); wait_done_s("rand_s");
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // Full frame, blue fill, with address sweep check.
        for (int i = 0; i < F_SIZE; i++) ram_f[i] = 12'h00F;
        start_full();
        errs = 0;
        if (int'(addr_f) != 0) errs++;
        for (int k = 2; k <= F_SIZE; k++) begin
            @(negedge clk);
            if (int'(addr_f) != k - 1 || !busy_f) errs++;
        end
        check("f_addr_sweep_errs", errs, 0);
        @(negedge clk);
        check("f_drain_addr", int'(addr_f), F_SIZE - 1);
        wait_done_f("f_blue", 10);
        @(negedge clk);

        // Full frame, random fill.
        for (int i = 0; i < F_SIZE; i++) ram_f[i] = rand_px();
        start_full();
        wait_done_f("f_rand", F_SIZE + 10);
        repeat (2) @(negedge clk);

        // Reset mid-scan at mem_addr=100.
        start_full();
        n = 0;
        while (int'(addr_f) != 100 && n < 200) begin @(negedge clk); n++; end
        check("f_reach_addr100", int'(addr_f), 100);
        rst_f = 1'b1;
        q_f.delete();
        @(negedge clk);
        check("mid_rst_busy", int'(busy_f), 0);
        check("mid_rst_done", int'(done_f), 0);
        check("mid_rst_addr", int'(addr_f), 0);
        check("mid_rst_color", int'(color_f), 0);
        check("mid_rst_counts", int'(rc_f) + int'(gc_f) + int'(bc_f), 0);
        rst_f = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_rst_idle", int'(busy_f), 0);

        repeat (5) @(negedge clk);
        check("sb_s_empty", q_s.size(), 0);
        check("sb_f_empty", q_f.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_color_scan.md
# frame_color_scan

Downstream consumer of the camera frame buffer: on request, reads every RGB444 pixel of the 160x120 image from the read port of the dual-port RAM and classifies each pixel as red, green, blue or none. It counts each class and reports the dominant colour of the frame. It runs in the system clock domain, alongside the VGA reader, and feeds the team's figure/colour detection logic.

## Interface

Parameters:
- AW, 15: frame-buffer address width.
- DW, 12: pixel width, RGB444 as {R[11:8], G[7:4], B[3:0]}.
- IMG_SIZE, 19200: pixels per frame; addresses 0..IMG_SIZE-1.
- MIN_LVL, 4: minimum 4-bit level of the winning component for a pixel to be classified.
- MIN_COUNT, 100: minimum class count for a colour to be reported dominant.

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1: system clock.
- rst, in, 1: synchronous active-high reset.
- start, in, 1: scan request; accepted only in IDLE.
- busy, out, 1: high in SCAN, DRAIN and DECIDE.
- done, out, 1: one-cycle pulse; result and counts are valid.
- mem_addr, out, AW: RAM read address.
- mem_data, in, DW: RAM read data; equals M[mem_addr of the previous cycle].
- color, out, 2: 0 = none, 1 = red, 2 = green, 3 = blue.
- red_cnt, green_cnt, blue_cnt, out, AW each: class counts of the last completed scan.

## Operation

- States: IDLE, SCAN, DRAIN, DECIDE, DONE.
- IDLE -> SCAN when start=1. On that edge, clear the internal counters and set mem_addr=0.
- SCAN: increment mem_addr by 1 each cycle. When mem_addr==IMG_SIZE-1, go to DRAIN; mem_addr holds that value.
- DRAIN: one cycle that absorbs the last pixel. Then go to DECIDE.
- DECIDE: compute the result, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- A read-valid flag, delayed one cycle from SCAN, qualifies mem_data. Each qualified pixel increments at most one class counter.
- Pixel classification, with R, G, B taken as 4-bit unsigned values:
  - red if R>G, R>B and R>=MIN_LVL;
  - green if G>R, G>B and G>=MIN_LVL;
  - blue if B>R, B>G and B>=MIN_LVL;
  - otherwise none, including any tie for the maximum component.
- Dominant colour is the class with the largest count.
  - Count ties resolve with priority red > green > blue.
  - If the winning count is below MIN_COUNT, color=0.
- Registered outputs: color, red_cnt, green_cnt and blue_cnt update only at the end of DECIDE, and hold until the next DECIDE.
- start is ignored in every state other than IDLE, including DONE.
- rst mid-scan: the next cycle is IDLE, and all outputs take their reset values. Any partial result is discarded.
- Counters are AW bits wide. IMG_SIZE <= 2^AW - 1 is required, so counts cannot overflow.

## Timing

- Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- Cycle k, for 1<=k<=IMG_SIZE: SCAN, mem_addr=k-1.
- Cycle IMG_SIZE+1: DRAIN; mem_data holds pixel IMG_SIZE-1.
- Cycle IMG_SIZE+2: DECIDE.
- Cycle IMG_SIZE+3: done=1, busy=0, and results are valid.
- Total: IMG_SIZE+3 cycles from start to done. The earliest next start that can be accepted is cycle IMG_SIZE+4.
- busy is high from cycle 1 through cycle IMG_SIZE+2.
- Reset values: busy=0, done=0, mem_addr=0, color=0, red_cnt=green_cnt=blue_cnt=0, state IDLE.
- The block does not arbitrate frame tearing. The writer may update the RAM during a scan; the result reflects whatever data was read.

## Structure

- Shared package: colour codes (NONE, RED, GREEN, BLUE as 2-bit constants), the state enumeration, and the RGB444 field positions.
- One sub-module, frame_pixel_classify: combinational. Takes a DW-bit pixel and MIN_LVL and returns a 2-bit class. It is reused by the figure-detection logic.
- The top level holds the FSM, the address counter, the valid delay, three count registers, and the decision comparator.

## Test plan

- Reset: rst for 2 cycles, then idle. All outputs are 0; start held during rst is ignored.
- IMG_SIZE=4, RAM = {F00, F00, 0F0, 000}, start -> done at cycle 7; color=1, red_cnt=2, green_cnt=1, blue_cnt=0 (MIN_COUNT=1).
- Tie and threshold cases, IMG_SIZE=4:
  - RAM = {0F0, 00F, 0F0, 00F} -> color=2 (green wins tie over blue).
  - RAM = {300, 300, 300, 300} -> all counts 0, color=0 (below MIN_LVL).
  - RAM = {FF0, 888, 0FF, F0F} -> all counts 0 (component ties).
- Full frame with the default parameters: blue fill 00F -> blue_cnt=19200, color=3, done exactly 19203 cycles after start. mem_addr sweeps 0..19199 with no gaps and no wrap.
- Handshake: start pulses during SCAN and DONE are ignored; a new start in the cycle after DONE is accepted. Back-to-back scans give independent counts.
- Reset mid-scan at mem_addr=100: the next cycle is IDLE with busy=0. The previous result is cleared to 0 and no done pulse occurs.
